// File: rtl/ahb_slave_mem.sv
// ahb_slave_mem -- AHB-Lite slave fronting a word-organised on-chip memory.
//
// Accepts pipelined NONSEQ/SEQ transfers, checks address range and alignment,
// answers legal transfers with OKAY after an optional number of wait states,
// and answers illegal ones with the two-cycle ERROR response.
//
// Parameters:
//   ADDR_BASE   byte address of memory word 0
//   MEM_DEPTH   number of 32-bit words (power of two, >= 4)
//   WAIT_STATES wait cycles per OKAY data phase (0..15)
//
// Configuration macro:
//   AHB_SLAVE_MEM_WAIT_EN  when defined, OKAY data phases are stretched by
//                          WAIT_STATES cycles; when undefined the wait-state
//                          counter is not built and every legal transfer
//                          completes with zero wait states.
//
// Ports:
//   clk        single clock, rising edge
//   rst        asynchronous active-low reset
//   HSel       slave select
//   HTrans     transfer type (IDLE/BUSY/NONSEQ/SEQ)
//   HWrite     1 = write, 0 = read
//   HAddr      byte address
//   HSize      00 byte, 01 halfword, 10 word, 11 illegal
//   HWData     write data (data phase)
//   HWStrb     byte-lane write enables (data phase)
//   HReadyOut  data phase completes this cycle
//   HResp      00 OKAY, 01 ERROR
//   HRData     read data, zero outside a completing OKAY read phase
module ahb_slave_mem #(
  parameter logic [31:0] ADDR_BASE   = 32'h0000_0000,
  parameter int unsigned MEM_DEPTH   = 256,
  parameter int unsigned WAIT_STATES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        HSel,
  input  logic [1:0]  HTrans,
  input  logic        HWrite,
  input  logic [31:0] HAddr,
  input  logic [1:0]  HSize,
  input  logic [31:0] HWData,
  input  logic [3:0]  HWStrb,
  output logic        HReadyOut,
  output logic [1:0]  HResp,
  output logic [31:0] HRData
);

  localparam int unsigned IDX_W     = $clog2(MEM_DEPTH);
  // One bit wider than the bus so a window ending at 4 GiB does not overflow.
  localparam logic [32:0] ADDR_END  = {1'b0, ADDR_BASE} + 33'(MEM_DEPTH) * 33'd4;
  localparam logic [1:0]  TR_NONSEQ = 2'b10;
  localparam logic [1:0]  TR_SEQ    = 2'b11;
  localparam logic [1:0]  RESP_OKAY = 2'b00;
  localparam logic [1:0]  RESP_ERR  = 2'b01;

  if (MEM_DEPTH < 4 || (MEM_DEPTH & (MEM_DEPTH - 1)) != 0 || WAIT_STATES > 15)
  begin : g_bad_params
    $error("ahb_slave_mem: MEM_DEPTH or WAIT_STATES out of range");
  end

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ERR1, S_ERR2} state_e;

  state_e           state_q, state_d;
  logic             pend_q, pend_d;    // a legal data phase is outstanding
  logic             write_q, write_d;
  logic [IDX_W-1:0] idx_q, idx_d;
`ifdef AHB_SLAVE_MEM_WAIT_EN
  logic [3:0]       cnt_q, cnt_d;
`endif

  logic [31:0] mem [MEM_DEPTH];

  logic accept;
  logic size_ok;
  logic range_ok;
  logic legal;
  logic mem_we;

  always_comb begin
    case (HSize)
      2'b00:   size_ok = 1'b1;
      2'b01:   size_ok = ~HAddr[0];
      2'b10:   size_ok = (HAddr[1:0] == 2'b00);
      default: size_ok = 1'b0;
    endcase
  end

  assign range_ok = (HAddr >= ADDR_BASE) && ({1'b0, HAddr} < ADDR_END);
  assign legal    = range_ok && size_ok;

  // NOTE: every signal assigned here gets a default first so no path through
  // the case/if tree leaves one unassigned and infers a latch.
  always_comb begin
    state_d   = state_q;
    pend_d    = pend_q;
    write_d   = write_q;
    idx_d     = idx_q;
    HReadyOut = 1'b1;
    HResp     = RESP_OKAY;
`ifdef AHB_SLAVE_MEM_WAIT_EN
    cnt_d     = cnt_q;
`endif

    case (state_q)
`ifdef AHB_SLAVE_MEM_WAIT_EN
      S_WAIT: begin
        HReadyOut = (cnt_q == 4'd0);
        if (cnt_q != 4'd0) cnt_d = cnt_q - 4'd1;
      end
`endif
      S_ERR1: begin
        HReadyOut = 1'b0;
        HResp     = RESP_ERR;
        state_d   = S_ERR2;
      end
      S_ERR2: HResp = RESP_ERR;
      default: ;
    endcase

    // Only BUSY/IDLE fall outside NONSEQ/SEQ; both are ignored.
    accept = HSel && HReadyOut && (HTrans == TR_NONSEQ || HTrans == TR_SEQ);

    // Whenever HReadyOut is high the current data phase (if any) ends, and a
    // new address phase may be taken in the same cycle.
    if (HReadyOut) begin
      state_d = S_IDLE;
      pend_d  = 1'b0;
      if (accept) begin
        write_d = HWrite;
        idx_d   = IDX_W'((HAddr - ADDR_BASE) >> 2);
        if (!legal) begin
          state_d = S_ERR1;
        end else begin
          pend_d = 1'b1;
`ifdef AHB_SLAVE_MEM_WAIT_EN
          if (WAIT_STATES != 0) begin
            state_d = S_WAIT;
            cnt_d   = 4'(WAIT_STATES);
          end
`endif
        end
      end
    end
  end

  // Error states never carry a pending phase, so this only fires on OKAY.
  assign mem_we = pend_q && write_q && HReadyOut;
  assign HRData = (pend_q && !write_q && HReadyOut) ? mem[idx_q] : 32'h0;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      pend_q  <= 1'b0;
      write_q <= 1'b0;
      idx_q   <= '0;
`ifdef AHB_SLAVE_MEM_WAIT_EN
      cnt_q   <= 4'd0;
`endif
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      write_q <= write_d;
      idx_q   <= idx_d;
`ifdef AHB_SLAVE_MEM_WAIT_EN
      cnt_q   <= cnt_d;
`endif
    end
  end

  // NOTE: the storage array has no reset; it maps onto plain RAM and its
  // contents survive rst. Reset still blocks writes because it clears pend_q.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int b = 0; b < 4; b++) begin
        if (HWStrb[b]) mem[idx_q][8*b +: 8] <= HWData[8*b +: 8];
      end
    end
  end

endmodule

// File: tb/tb_ahb_slave_mem.sv
// tb_ahb_slave_mem -- self-checking bench for ahb_slave_mem (default params).
// Single transfers come from a vector table; pipelined sequences and a reset
// in the middle of a data phase are hand-written.
module tb_ahb_slave_mem;

`ifdef AHB_SLAVE_MEM_WAIT_EN
  localparam int EW = 2;
`else
  localparam int EW = 0;
`endif

  logic        clk;
  logic        rst;
  logic        HSel;
  logic [1:0]  HTrans;
  logic        HWrite;
  logic [31:0] HAddr;
  logic [1:0]  HSize;
  logic [31:0] HWData;
  logic [3:0]  HWStrb;
  logic        HReadyOut;
  logic [1:0]  HResp;
  logic [31:0] HRData;

  ahb_slave_mem #(
    .ADDR_BASE  (32'h0000_0000),
    .MEM_DEPTH  (256),
    .WAIT_STATES(2)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .HSel     (HSel),
    .HTrans   (HTrans),
    .HWrite   (HWrite),
    .HAddr    (HAddr),
    .HSize    (HSize),
    .HWData   (HWData),
    .HWStrb   (HWStrb),
    .HReadyOut(HReadyOut),
    .HResp    (HResp),
    .HRData   (HRData)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    bit          wr;
    logic [31:0] addr;
    logic [1:0]  size;
    logic [31:0] wdata;
    logic [3:0]  strb;
    logic [31:0] exp_rdata;
    logic [1:0]  exp_resp;
    int          exp_waits;
  } vec_t;

  int   checks   = 0;
  int   failures = 0;
  vec_t tbl [20];
  vec_t pipe [$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input string name, input bit wr, input logic [31:0] addr,
                              input logic [1:0] size, input logic [31:0] wdata,
                              input logic [3:0] strb, input logic [31:0] exp_rdata,
                              input bit err);
    vec_t v;
    v.name      = name;
    v.wr        = wr;
    v.addr      = addr;
    v.size      = size;
    v.wdata     = wdata;
    v.strb      = strb;
    v.exp_rdata = (err || wr) ? 32'h0 : exp_rdata;
    v.exp_resp  = err ? 2'b01 : 2'b00;
    v.exp_waits = err ? 1 : EW;
    return v;
  endfunction

  task automatic present(input int k);
    if (k < pipe.size()) begin
      HSel   = 1'b1;
      HTrans = 2'b10;
      HWrite = pipe[k].wr;
      HAddr  = pipe[k].addr;
      HSize  = pipe[k].size;
    end else begin
      HSel   = 1'b0;
      HTrans = 2'b00;
    end
  endtask

  // Runs the queued transfers back to back, one address phase overlapping the
  // previous data phase. Called and returns at posedge+1.
  task automatic run_pipe();
    int   n     = pipe.size();
    int   cur   = -1;
    int   nxt   = 0;
    int   done  = 0;
    int   waits = 0;
    logic rdy;
    present(nxt);
    for (int cyc = 0; cyc < 200 && done < n; cyc++) begin
      @(negedge clk);
      rdy = HReadyOut;
      if (cur >= 0) begin
        if (!rdy) begin
          waits++;
          check({pipe[cur].name, "_wait_resp"}, 32'(HResp), 32'(pipe[cur].exp_resp));
        end else begin
          check({pipe[cur].name, "_waits"}, 32'(waits), 32'(pipe[cur].exp_waits));
          check({pipe[cur].name, "_resp"}, 32'(HResp), 32'(pipe[cur].exp_resp));
          check({pipe[cur].name, "_rdata"}, HRData, pipe[cur].exp_rdata);
          done++;
        end
      end
      @(posedge clk);
      #1;
      if (rdy) begin
        if (nxt < n) begin
          cur    = nxt;
          HWData = pipe[cur].wdata;
          HWStrb = pipe[cur].strb;
          waits  = 0;
        end else begin
          cur = -1;
        end
        nxt++;
        present(nxt);
      end
    end
    check("pipe_completed", 32'(done), 32'(n));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0]  = mk("w_deadbeef",  1, 32'h010, 2'b10, 32'hDEADBEEF, 4'hF, 32'h0,         0);
    tbl[1]  = mk("r_deadbeef",  0, 32'h010, 2'b10, 32'h0,        4'h0, 32'hDEADBEEF,  0);
    tbl[2]  = mk("w_word0",     1, 32'h000, 2'b10, 32'h11223344, 4'hF, 32'h0,         0);
    tbl[3]  = mk("w_byte0",     1, 32'h000, 2'b00, 32'h000000AA, 4'h1, 32'h0,         0);
    tbl[4]  = mk("r_word0",     0, 32'h000, 2'b10, 32'h0,        4'h0, 32'h112233AA,  0);
    tbl[5]  = mk("w_oor",       1, 32'h400, 2'b10, 32'hFFFFFFFF, 4'hF, 32'h0,         1);
    tbl[6]  = mk("r_word0_b",   0, 32'h000, 2'b10, 32'h0,        4'h0, 32'h112233AA,  0);
    tbl[7]  = mk("r_oor",       0, 32'h400, 2'b10, 32'h0,        4'h0, 32'h0,         1);
    tbl[8]  = mk("w_misalign",  1, 32'h012, 2'b10, 32'h00000000, 4'hF, 32'h0,         1);
    tbl[9]  = mk("r_word4",     0, 32'h010, 2'b10, 32'h0,        4'h0, 32'hDEADBEEF,  0);
    tbl[10] = mk("w_word5",     1, 32'h014, 2'b10, 32'hCAFEF00D, 4'hF, 32'h0,         0);
    tbl[11] = mk("w_nostrb",    1, 32'h014, 2'b10, 32'hFFFFFFFF, 4'h0, 32'h0,         0);
    tbl[12] = mk("r_word5",     0, 32'h014, 2'b10, 32'h0,        4'h0, 32'hCAFEF00D,  0);
    tbl[13] = mk("w_half_odd",  1, 32'h015, 2'b01, 32'h00000000, 4'hF, 32'h0,         1);
    tbl[14] = mk("w_half_hi",   1, 32'h016, 2'b01, 32'hBEEF0000, 4'hC, 32'h0,         0);
    tbl[15] = mk("r_word5_b",   0, 32'h014, 2'b10, 32'h0,        4'h0, 32'hBEEFF00D,  0);
    tbl[16] = mk("r_size11",    0, 32'h014, 2'b11, 32'h0,        4'h0, 32'h0,         1);
    tbl[17] = mk("w_last",      1, 32'h3FC, 2'b10, 32'h12345678, 4'hF, 32'h0,         0);
    tbl[18] = mk("r_last",      0, 32'h3FC, 2'b10, 32'h0,        4'h0, 32'h12345678,  0);
    tbl[19] = mk("r_half_full", 0, 32'h002, 2'b01, 32'h0,        4'h0, 32'h112233AA,  0);

    rst    = 1'b0;
    HSel   = 1'b0;
    HTrans = 2'b00;
    HWrite = 1'b0;
    HAddr  = 32'h0;
    HSize  = 2'b10;
    HWData = 32'h0;
    HWStrb = 4'h0;

    #12;
    check("reset_ready", 32'(HReadyOut), 32'h1);
    check("reset_resp",  32'(HResp),     32'h0);
    check("reset_rdata", HRData,         32'h0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;

    // IDLE with select high must not start a transfer.
    HSel = 1'b1; HTrans = 2'b00; HWrite = 1'b1; HAddr = 32'h010;
    @(negedge clk);
    @(negedge clk);
    check("idle_ignored_ready", 32'(HReadyOut), 32'h1);
    check("idle_ignored_resp",  32'(HResp),     32'h0);
    @(posedge clk);
    #1;
    HSel = 1'b0;

    for (int i = 0; i < 20; i++) begin
      pipe.delete();
      pipe.push_back(tbl[i]);
      run_pipe();
    end

    // Back-to-back writes/reads, including write-then-read of the same word.
    pipe.delete();
    pipe.push_back(mk("p_w1", 1, 32'h004, 2'b10, 32'hA1A1A1A1, 4'hF, 32'h0, 0));
    pipe.push_back(mk("p_w2", 1, 32'h008, 2'b10, 32'hB2B2B2B2, 4'hF, 32'h0, 0));
    pipe.push_back(mk("p_w3", 1, 32'h00C, 2'b10, 32'hC3C3C3C3, 4'hF, 32'h0, 0));
    pipe.push_back(mk("p_r1", 0, 32'h004, 2'b10, 32'h0, 4'h0, 32'hA1A1A1A1, 0));
    pipe.push_back(mk("p_r2", 0, 32'h008, 2'b10, 32'h0, 4'h0, 32'hB2B2B2B2, 0));
    pipe.push_back(mk("p_r3", 0, 32'h00C, 2'b10, 32'h0, 4'h0, 32'hC3C3C3C3, 0));
    pipe.push_back(mk("p_w7", 1, 32'h01C, 2'b10, 32'h77777777, 4'hF, 32'h0, 0));
    pipe.push_back(mk("p_r7", 0, 32'h01C, 2'b10, 32'h0, 4'h0, 32'h77777777, 0));
    run_pipe();

    // A transfer held during ERR1 is accepted in ERR2.
    pipe.delete();
    pipe.push_back(mk("e_r_oor", 0, 32'h400, 2'b10, 32'h0, 4'h0, 32'h0, 1));
    pipe.push_back(mk("e_r4",    0, 32'h010, 2'b10, 32'h0, 4'h0, 32'hDEADBEEF, 0));
    pipe.push_back(mk("e_w_bad", 1, 32'h011, 2'b01, 32'h0, 4'hF, 32'h0, 1));
    pipe.push_back(mk("e_r4_b",  0, 32'h010, 2'b10, 32'h0, 4'h0, 32'hDEADBEEF, 0));
    run_pipe();

    // Reset inside the data phase of a write to word 5 aborts it.
    HSel = 1'b1; HTrans = 2'b10; HWrite = 1'b1; HAddr = 32'h014; HSize = 2'b10;
    @(posedge clk);
    #1;
    HSel = 1'b0; HTrans = 2'b00;
    HWData = 32'h55555555; HWStrb = 4'hF;
    #2;
    rst = 1'b0;
    #1;
    check("rst_mid_ready", 32'(HReadyOut), 32'h1);
    check("rst_mid_resp",  32'(HResp),     32'h0);
    check("rst_mid_rdata", HRData,         32'h0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    pipe.delete();
    pipe.push_back(mk("rst_r5", 0, 32'h014, 2'b10, 32'h0, 4'h0, 32'hBEEFF00D, 0));
    run_pipe();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ahb_slave_mem.md
AHB_SLAVE_MEM -- requirements
Module: ahb_slave_mem

Interface
REQ-001 Parameter ADDR_BASE, default 32'h0000_0000: byte address of memory word 0.
REQ-002 Parameter MEM_DEPTH, default 256: number of 32-bit words; power of two, at least 4.
REQ-003 Parameter WAIT_STATES, default 2: wait cycles per OKAY data phase; range 0..15.
REQ-004 clk  in  1  single clock; all state changes on its rising edge.
REQ-005 rst  in  1  asynchronous, active-low reset.
REQ-006 HSel  in  1  slave select.
REQ-007 HTrans  in  2  transfer type: 00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ.
REQ-008 HWrite  in  1  1 = write, 0 = read.
REQ-009 HAddr  in  32  byte address.
REQ-010 HSize  in  2  00 byte, 01 halfword, 10 word, 11 illegal.
REQ-011 HWData  in  32  write data; valid during the data phase.
REQ-012 HWStrb  in  4  byte-lane write enables; valid during the data phase.
REQ-013 HReadyOut  out  1  data phase completes this cycle.
REQ-014 HResp  out  2  00 OKAY, 01 ERROR.
REQ-015 HRData  out  32  read data; valid when HReadyOut=1 and HResp=00 in a read data phase.

Function
REQ-016 Address phase accepted when HSel=1, HTrans[1]=1 and HReadyOut=1. The block captures HWrite, word index, and legality. BUSY and IDLE are ignored and get a zero-wait OKAY.
REQ-017 Transfer is illegal when any of the following holds: HAddr < ADDR_BASE; HAddr >= ADDR_BASE+4*MEM_DEPTH; HSize=11; halfword with HAddr[0]=1; word with HAddr[1:0]!=00.
REQ-018 FSM states: IDLE, WAIT, ERR1, ERR2.
REQ-019 Transitions:
- IDLE -> WAIT: legal accept, wait count > 0.
- IDLE -> IDLE: legal accept, wait count = 0.
- IDLE -> ERR1: illegal accept.
- WAIT -> IDLE: when the counter reaches 0.
- ERR1 -> ERR2: unconditional.
- ERR2 -> IDLE, or re-enters per REQ-016.
REQ-020 WAIT and legal data phases: HReadyOut=0 while the counter is nonzero, then HReadyOut=1 with HResp=00. The counter loads WAIT_STATES on accept and decrements by 1 per cycle.
REQ-021 ERR1 drives HReadyOut=0, HResp=01. ERR2 drives HReadyOut=1, HResp=01. An illegal transfer never writes memory.
REQ-022 Write commits at the clock edge ending the OKAY data phase (HReadyOut=1). Only lanes with HWStrb=1 are updated; HWStrb=0000 leaves memory unchanged.
REQ-023 Read data phase: HRData = full 32-bit word at the captured index when HReadyOut=1. Otherwise HRData=0.
REQ-024 Pipelining: a new address phase may be accepted in the same cycle its predecessor's data phase completes, including ERR2. Back-to-back write then read of the same word returns the newly written value.
REQ-025 Address phases presented while HReadyOut=0 are ignored; the master holds them.
REQ-026 Word index = (HAddr-ADDR_BASE)[log2(MEM_DEPTH)+1:2]. No wrap-around; out-of-range is an error per REQ-017.

Reset
REQ-027 rst=0 forces asynchronously: state IDLE, counter 0, HReadyOut=1, HResp=00, HRData=0.
REQ-028 Memory contents are not reset.
REQ-029 Reset during WAIT aborts the pending transfer. No memory write occurs, and the first access after reset release is treated as a new address phase.

Configuration
REQ-030 Macro AHB_SLAVE_MEM_WAIT_EN. When defined, wait states per REQ-020 use WAIT_STATES.
REQ-031 When AHB_SLAVE_MEM_WAIT_EN is undefined:
- The WAIT state and counter are not built.
- Every legal transfer completes with zero wait states.
- WAIT_STATES is ignored.
- Error behaviour is unchanged.

Verification
REQ-032 Word write 0xDEADBEEF to ADDR_BASE+0x10, strobe 1111, WAIT_STATES=2, then read the same address -> exactly 2 cycles HReadyOut=0 per phase; read returns 0xDEADBEEF, HResp=00.
REQ-033 Write 0x11223344 to word 0, then byte write 0x000000AA with strobe 0001 -> readback 0x112233AA.
REQ-034 Read at ADDR_BASE+4*MEM_DEPTH -> ERR1 (HReadyOut=0, HResp=01), then ERR2 (HReadyOut=1, HResp=01); memory unchanged.
REQ-035 Word write at address offset 0x2 -> two-cycle ERROR response; no memory change.
REQ-036 Back-to-back NONSEQ writes to words 1, 2, 3, then reads of 1, 2, 3, with AHB_SLAVE_MEM_WAIT_EN undefined -> each phase completes in one cycle with correct data.
REQ-037 Assert rst=0 in the 1st WAIT cycle of a write to word 5 -> outputs at reset values immediately; word 5 retains its old value.
